// File: rtl/abro_rr_controller.sv
// Round-robin shared ABRO evaluator: N channels, one accepted A/B/R event per cycle, O reported with channel id.
// Optional partial-state timeout enabled by defining ABRO_TIMEOUT_EN.

module abro_rr_chan #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       xfer_i,
    input  logic       a_i,
    input  logic       b_i,
    input  logic       r_i,
    output logic [3:0] state_o,
    output logic       hit_o,
    output logic       tmo_o
);
    typedef enum logic [3:0] {
        WAIT_AB = 4'b0001,
        WAIT_B  = 4'b0010,
        WAIT_A  = 4'b0100,
        DONE    = 4'b1000
    } abro_st_e;

    logic [3:0] state_q, state_d;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("abro_rr_chan: TIMEOUT must be >= 1");
    end

    always_comb begin
        state_d = state_q;
        hit_o   = 1'b0;
        if (xfer_i) begin
            if (r_i) begin
                state_d = WAIT_AB;
            end else begin
                case (state_q)
                    WAIT_AB: begin
                        if (a_i && b_i) begin
                            state_d = DONE;
                            hit_o   = 1'b1;
                        end else if (a_i) begin
                            state_d = WAIT_B;
                        end else if (b_i) begin
                            state_d = WAIT_A;
                        end
                    end
                    WAIT_B: if (b_i) begin
                        state_d = DONE;
                        hit_o   = 1'b1;
                    end
                    WAIT_A: if (a_i) begin
                        state_d = DONE;
                        hit_o   = 1'b1;
                    end
                    DONE:    state_d = DONE;
                    default: state_d = WAIT_AB;
                endcase
            end
        end
    end

    assign state_o = state_q;

`ifdef ABRO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q;
    logic          tmo_q;
    logic          part_q, part_d, expire;

    always_comb begin
        part_q = (state_q == WAIT_A) || (state_q == WAIT_B);
        part_d = (state_d == WAIT_A) || (state_d == WAIT_B);
        // A transfer in the expiry cycle takes precedence over the timeout.
        expire = part_q && !xfer_i && (cnt_q == TW'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_AB;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= expire;
            if (expire) begin
                state_q <= WAIT_AB;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                if (!part_d || (state_d != state_q))
                    cnt_q <= '0;
                else if (cnt_q != TW'(TIMEOUT))
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign tmo_o = tmo_q;
`else
    always_ff @(posedge clk) begin
        if (reset) state_q <= WAIT_AB;
        else       state_q <= state_d;
    end

    assign tmo_o = 1'b0;
`endif
endmodule

module abro_rr_controller #(
    parameter int N       = 4,
    parameter int CW      = $clog2(N),
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_valid,
    input  logic [N-1:0]  req_a,
    input  logic [N-1:0]  req_b,
    input  logic [N-1:0]  req_r,
    output logic [N-1:0]  req_ready,
    output logic          o_valid,
    output logic [CW-1:0] o_chan,
    input  logic [CW-1:0] state_rd_sel,
    output logic [3:0]    state_rd,
    output logic [N-1:0]  timeout_flags
);
    if (N < 2 || N > 16 || CW != $clog2(N)) begin : g_bad_params
        $error("abro_rr_controller: N must be 2..16 and CW = $clog2(N)");
    end

    logic [CW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       gnt_idx, cand;
    logic                any_gnt;
    logic [N-1:0]        hit;
    logic [N-1:0][3:0]   st;
    logic                o_valid_q;
    logic [CW-1:0]       o_chan_q;

    // First valid channel at or after ptr, wrapping; nothing granted while in reset.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        cand      = '0;
        any_gnt   = 1'b0;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                cand = CW'((int'(ptr_q) + k) % N);
                if (!any_gnt && req_valid[cand]) begin
                    any_gnt = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (any_gnt) req_ready[gnt_idx] = 1'b1;
        end
        ptr_d = any_gnt ? CW'((int'(gnt_idx) + 1) % N) : ptr_q;
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        abro_rr_chan #(.TIMEOUT(TIMEOUT)) u_chan (
            .clk     (clk),
            .reset   (reset),
            .xfer_i  (req_valid[i] & req_ready[i]),
            .a_i     (req_a[i]),
            .b_i     (req_b[i]),
            .r_i     (req_r[i]),
            .state_o (st[i]),
            .hit_o   (hit[i]),
            .tmo_o   (timeout_flags[i])
        );
    end

    // Only the granted channel can hit, so its index is the O channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            o_valid_q <= 1'b0;
            o_chan_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            o_valid_q <= |hit;
            if (|hit) o_chan_q <= gnt_idx;
        end
    end

    assign o_valid = o_valid_q;
    assign o_chan  = o_chan_q;

    always_comb begin
        state_rd = 4'b0000;
        for (int i = 0; i < N; i++)
            if (state_rd_sel == CW'(i)) state_rd = st[i];
    end
endmodule

// File: tb/tb_abro_rr_controller.sv
// Randomized + directed bench for abro_rr_controller against a seen-A/seen-B behavioural model.
module tb_abro_rr_controller;
    localparam int N  = 4;
    localparam int CW = 2;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid, req_a, req_b, req_r, req_ready, timeout_flags;
    logic          o_valid;
    logic [CW-1:0] o_chan, sel;
    logic [3:0]    state_rd;

    int errors = 0;
    int checks = 0;

    abro_rr_controller #(.N(N), .CW(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_r(req_r), .req_ready(req_ready), .o_valid(o_valid), .o_chan(o_chan),
        .state_rd_sel(sel), .state_rd(state_rd), .timeout_flags(timeout_flags)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [3:0] enc(input bit a, input bit b);
        return {a & b, b & ~a, a & ~b, ~a & ~b};
    endfunction

    // Model: per channel, has A / has B been seen since the last R.
    bit           sa[N], sb[N];
    int           cnt[N];
    int           ptr = 0;
    bit           exp_ov = 0;
    int           exp_oc = 0;
    logic [N-1:0] exp_tmo = '0;

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] ntmo;
        int g;
        bit hit, was_p;
        eg = '0; g = -1; hit = 0; ntmo = '0;
        if (!reset)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", req_ready, eg);
        chk("state_rd", state_rd, enc(sa[sel], sb[sel]));
        chk("o_valid", o_valid, exp_ov);
        if (exp_ov) chk("o_chan", o_chan, exp_oc);
        chk("timeout_flags", timeout_flags, exp_tmo);

        if (reset) begin
            for (int i = 0; i < N; i++) begin sa[i] = 0; sb[i] = 0; cnt[i] = 0; end
            ptr = 0; exp_ov = 0; exp_oc = 0; exp_tmo = '0;
        end else begin
`ifdef ABRO_TIMEOUT_EN
            for (int i = 0; i < N; i++) begin
                if (i != g) begin
                    if (sa[i] ^ sb[i]) begin
                        if (cnt[i] == TO) begin
                            sa[i] = 0; sb[i] = 0; cnt[i] = 0; ntmo[i] = 1'b1;
                        end else cnt[i]++;
                    end else cnt[i] = 0;
                end
            end
`endif
            if (g >= 0) begin
                was_p = sa[g] ^ sb[g];
                if (req_r[g]) begin
                    sa[g] = 0; sb[g] = 0;
                end else if (!(sa[g] && sb[g])) begin
                    hit = (req_a[g] || sa[g]) && (req_b[g] || sb[g]);
                    sa[g] = sa[g] | req_a[g];
                    sb[g] = sb[g] | req_b[g];
                end
`ifdef ABRO_TIMEOUT_EN
                if (!(sa[g] ^ sb[g]) || !was_p) cnt[g] = 0;
                else if (cnt[g] < TO) cnt[g]++;
`else
                if (was_p) cnt[g] = 0;
`endif
                if (hit) exp_oc = g;
                ptr = (g + 1) % N;
            end
            exp_ov = hit; exp_tmo = ntmo;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input int ch, input bit a, input bit b, input bit r);
        int n;
        n = 0;
        req_valid[ch] = 1'b1; req_a[ch] = a; req_b[ch] = b; req_r[ch] = r;
        #1;
        while (!req_ready[ch] && n <= 50) begin step(); #1; n++; end
        if (n > 50) begin
            checks++; errors++;
            $display("FAIL send_grant: ch %0d got no grant within 50 cycles", ch);
        end
        step();
        req_valid[ch] = 1'b0; req_a[ch] = 1'b0; req_b[ch] = 1'b0; req_r[ch] = 1'b0;
    endtask

    task automatic rd(input int ch, input string nm, input logic [3:0] exp);
        sel = CW'(ch); #1;
        chk(nm, state_rd, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] taken;
        reset = 1'b1; req_valid = '1; req_a = '0; req_b = '0; req_r = '0; sel = '0;
        // Reset with every channel requesting: nothing granted.
        repeat (2) begin step(); #1; chk("rst_ready", req_ready, 4'b0000); end
        for (int i = 0; i < N; i++) rd(i, "rst_state", 4'b0001);
        chk("rst_o_valid", o_valid, 1'b0);
        step(); reset = 1'b0; req_valid = '0;

        // Ch1: A then B, then a further A.
        send(1, 1, 0, 0); rd(1, "ch1_after_a", 4'b0010);
        chk("ch1_no_o", o_valid, 1'b0);
        step(); send(1, 0, 1, 0);
        chk("ch1_o_valid", o_valid, 1'b1);
        chk("ch1_o_chan", o_chan, 2'd1);
        rd(1, "ch1_done", 4'b1000);
        step(); chk("ch1_o_pulse", o_valid, 1'b0);
        send(1, 1, 0, 0); chk("ch1_no_repeat", o_valid, 1'b0);

        // Round-robin sweep from ptr = 0.
        reset = 1'b1; step(); reset = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1; chk("rr_grant", req_ready, 4'b0001 << (k % 4));
            step();
        end
        req_valid = '0;

        // Ch2: DONE, then R with A&B, then A&B again.
        step(); send(2, 1, 1, 0); chk("ch2_o", o_valid, 1'b1); chk("ch2_chan", o_chan, 2'd2);
        step(); send(2, 1, 1, 1); chk("ch2_r_no_o", o_valid, 1'b0); rd(2, "ch2_restart", 4'b0001);
        step(); send(2, 1, 1, 0); chk("ch2_o_again", o_valid, 1'b1); chk("ch2_chan_again", o_chan, 2'd2);

        // Reset during a ch3 transfer that would reach DONE.
        step();
        req_valid[3] = 1'b1; req_a[3] = 1'b1; req_b[3] = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        rd(3, "ch3_rst_state", 4'b0001); chk("ch3_rst_no_o", o_valid, 1'b0);
        step(); chk("ch3_rst_no_o2", o_valid, 1'b0);

`ifdef ABRO_TIMEOUT_EN
        // Ch0 A then idle: times out after 16 edges.
        send(0, 1, 0, 0); sel = '0;
        for (int k = 1; k <= 15; k++) begin step(); chk("tmo_hold", state_rd, 4'b0010); end
        step(); chk("tmo_state", state_rd, 4'b0001); chk("tmo_flag", timeout_flags, 4'b0001);
        step(); chk("tmo_flag_pulse", timeout_flags, 4'b0000);
        // B accepted on the expiry cycle wins.
        send(0, 1, 0, 0); sel = '0;
        repeat (15) step();
        send(0, 0, 1, 0);
        chk("tmo_race_state", state_rd, 4'b1000); chk("tmo_race_o", o_valid, 1'b1);
        chk("tmo_race_flag", timeout_flags, 4'b0000);
        step(); chk("tmo_race_flag2", timeout_flags, 4'b0000);
`endif

        // Random traffic; requests held stable until accepted.
        taken = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset = ($urandom_range(0, 99) == 0);
            sel = CW'($urandom_range(0, N - 1));
            for (int i = 0; i < N; i++) begin
                if (taken[i]) begin
                    req_valid[i] = 1'b0; req_a[i] = 1'b0; req_b[i] = 1'b0; req_r[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i] = 1'($urandom_range(0, 1));
                    req_b[i] = 1'($urandom_range(0, 1));
                    req_r[i] = ($urandom_range(0, 7) == 0);
                end
            end
            #3;
            taken = req_valid & req_ready;
            step();
        end
        reset = 1'b0; req_valid = '0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
